// File: rtl/prog_ctrl_ras_if.sv
// prog_ctrl_ras_if: decoder-to-PC control bundle and PC/stack status
interface prog_ctrl_ras_if #(
  parameter int PC_W = 7,
  parameter int RAS_DEPTH = 4
);
  logic stall, branch, branch_conditional, branch_rel;
  logic [1:0] cond_sel;
  logic zero, neg, call, ret;
  logic [PC_W-1:0] target, PC;
  logic taken;
  logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;
  logic ras_overflow, ras_underflow;
  modport master (
    output stall, branch, branch_conditional, branch_rel, cond_sel, zero, neg, call, ret, target,
    input PC, taken, ras_count, ras_overflow, ras_underflow
  );
  modport slave (
    input stall, branch, branch_conditional, branch_rel, cond_sel, zero, neg, call, ret, target,
    output PC, taken, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/prog_ctrl_ras.sv
// prog_ctrl_ras: PC sequencer with conditional/relative branches, stall and return-address stack; PROG_CTRL_PERF_CNT_EN adds perf_taken_cnt
module prog_ctrl_ras #(
  parameter int PC_W = 7,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC = 0
) (
  input logic clk,
  input logic reset,
`ifdef PROG_CTRL_PERF_CNT_EN
  output logic [15:0] perf_taken_cnt,
`endif
  prog_ctrl_ras_if.slave bus
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [PC_W-1:0] stk [RAS_DEPTH];
  logic [PC_W-1:0] pc_inc, nxt_pc;
  logic cond, br_take, empty, full, push, pop, nxt_taken;
  assign pc_inc = bus.PC + 1'b1;
  assign empty = bus.ras_count == '0;
  assign full = bus.ras_count == FULL;
  assign cond = bus.cond_sel[1] ? (bus.neg ^ bus.cond_sel[0]) : (bus.zero ^ bus.cond_sel[0]);
  assign br_take = bus.branch && (!bus.branch_conditional || cond);
  assign push = bus.call && !bus.ret && !full;
  assign pop = bus.ret && !empty;
  assign nxt_pc = bus.ret ? (empty ? pc_inc : stk[AW'(bus.ras_count - 1'b1)]) :
                  bus.call ? bus.target :
                  br_take ? (bus.branch_rel ? bus.PC + bus.target : bus.target) : pc_inc;
  assign nxt_taken = bus.ret ? !empty : (bus.call || br_take);
  // stack contents are don't-care across reset, so the array carries no reset
  always_ff @(posedge clk)
    if (!bus.stall && push) stk[AW'(bus.ras_count)] <= pc_inc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.PC <= PC_W'(RESET_PC);
      bus.taken <= 1'b0;
      bus.ras_count <= '0;
      bus.ras_overflow <= 1'b0;
      bus.ras_underflow <= 1'b0;
    end else if (bus.stall) begin
      bus.taken <= 1'b0;
    end else begin
      bus.PC <= nxt_pc;
      bus.taken <= nxt_taken;
      bus.ras_count <= push ? bus.ras_count + 1'b1 : pop ? bus.ras_count - 1'b1 : bus.ras_count;
      bus.ras_overflow <= bus.ras_overflow | (bus.call && !bus.ret && full);
      bus.ras_underflow <= bus.ras_underflow | (bus.ret && empty);
    end
  end
`ifdef PROG_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) perf_taken_cnt <= '0;
    else if (!bus.stall && nxt_taken && perf_taken_cnt != 16'hFFFF) perf_taken_cnt <= perf_taken_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_prog_ctrl_ras.sv
// tb_prog_ctrl_ras: directed vectors with a scoreboard queue checked by a separate monitor
module tb_prog_ctrl_ras;
  localparam int BR = 1, BC = 2, REL = 4, CALL = 8, RET = 16, STALL = 32, Z = 64, N = 128;
  typedef struct {
    int id;
    logic [6:0] pc;
    logic tk;
    logic [2:0] cnt;
    logic ov, un;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, vid = 0;
  prog_ctrl_ras_if #(.PC_W(7), .RAS_DEPTH(4)) bus ();
`ifdef PROG_CTRL_PERF_CNT_EN
  logic [15:0] perf_taken_cnt;
`endif
  prog_ctrl_ras #(.PC_W(7), .RAS_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk),
    .reset(reset),
`ifdef PROG_CTRL_PERF_CNT_EN
    .perf_taken_cnt(perf_taken_cnt),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, req);
    end
  endtask
  // drive one vector at a negedge, queue its expected post-edge state, advance to next negedge
  task automatic go(input logic [6:0] tgt, input int ctl, input logic [1:0] cs,
                    input logic [6:0] epc, input logic etk, input logic [2:0] ec, input logic eo, input logic eu);
    exp_t e;
    bus.target = tgt;
    bus.branch = (ctl & BR) != 0;
    bus.branch_conditional = (ctl & BC) != 0;
    bus.branch_rel = (ctl & REL) != 0;
    bus.call = (ctl & CALL) != 0;
    bus.ret = (ctl & RET) != 0;
    bus.stall = (ctl & STALL) != 0;
    bus.zero = (ctl & Z) != 0;
    bus.neg = (ctl & N) != 0;
    bus.cond_sel = cs;
    e.id = vid++;
    e.pc = epc;
    e.tk = etk;
    e.cnt = ec;
    e.ov = eo;
    e.un = eu;
    q.push_back(e);
    @(negedge clk);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", e.id, 32'(bus.PC), 32'(e.pc));
        chk("taken", e.id, 32'(bus.taken), 32'(e.tk));
        chk("ras_count", e.id, 32'(bus.ras_count), 32'(e.cnt));
        chk("ras_overflow", e.id, 32'(bus.ras_overflow), 32'(e.ov));
        chk("ras_underflow", e.id, 32'(bus.ras_underflow), 32'(e.un));
      end
    end
  end
  initial begin
    int wait_cyc;
    bus.target = '0; bus.branch = 0; bus.branch_conditional = 0; bus.branch_rel = 0;
    bus.call = 0; bus.ret = 0; bus.stall = 0; bus.zero = 0; bus.neg = 0; bus.cond_sel = '0;
    #1;
    chk("rst_pc", 0, 32'(bus.PC), 0);
    chk("rst_taken", 0, 32'(bus.taken), 0);
    chk("rst_count", 0, 32'(bus.ras_count), 0);
    chk("rst_flags", 0, 32'({bus.ras_overflow, bus.ras_underflow}), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 130; i++) go(0, 0, 0, 7'((i + 1) % 128), 0, 0, 0, 0);
    go(9, BR, 0, 9, 1, 0, 0, 0);
    go(0, 0, 0, 10, 0, 0, 0, 0);
    go(40, BR | BC | Z, 1, 11, 0, 0, 0, 0);
    go(40, BR | BC, 1, 40, 1, 0, 0, 0);
    go(60, BR | BC | Z, 0, 60, 1, 0, 0, 0);
    go(0, BR | BC, 2, 61, 0, 0, 0, 0);
    go(20, BR | BC, 3, 20, 1, 0, 0, 0);
    go(7'h7C, BR | REL, 0, 16, 1, 0, 0, 0);
    go(126, BR, 0, 126, 1, 0, 0, 0);
    go(5, BR | REL, 0, 3, 1, 0, 0, 0);
    go(0, 0, 0, 4, 0, 0, 0, 0);
    go(0, 0, 0, 5, 0, 0, 0, 0);
    go(50, CALL | BR, 0, 50, 1, 1, 0, 0);
    go(0, RET, 0, 6, 1, 0, 0, 0);
    go(0, RET, 0, 7, 0, 0, 0, 1);
    go(99, RET | CALL, 0, 8, 0, 0, 0, 1);
    go(0, BR, 0, 0, 1, 0, 0, 1);
    go(1, CALL, 0, 1, 1, 1, 0, 1);
    go(2, CALL, 0, 2, 1, 2, 0, 1);
    go(3, CALL, 0, 3, 1, 3, 0, 1);
    go(9, CALL, 0, 9, 1, 4, 0, 1);
    go(100, CALL, 0, 100, 1, 4, 1, 1);
    go(0, RET, 0, 4, 1, 3, 1, 1);
    go(0, RET, 0, 3, 1, 2, 1, 1);
    go(0, RET, 0, 2, 1, 1, 1, 1);
    go(0, RET, 0, 1, 1, 0, 1, 1);
    go(30, CALL, 0, 30, 1, 1, 1, 1);
    go(90, RET | BR, 0, 2, 1, 0, 1, 1);
    go(70, CALL | STALL, 0, 2, 0, 0, 1, 1);
    go(70, CALL | STALL, 0, 2, 0, 0, 1, 1);
    go(70, CALL | STALL, 0, 2, 0, 0, 1, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_pc", 1, 32'(bus.PC), 0);
    chk("async_taken", 1, 32'(bus.taken), 0);
    chk("async_count", 1, 32'(bus.ras_count), 0);
    chk("async_flags", 1, 32'({bus.ras_overflow, bus.ras_underflow}), 0);
    @(negedge clk);
    reset = 1'b1;
    go(0, 0, 0, 1, 0, 0, 0, 0);
    go(5, CALL, 0, 5, 1, 1, 0, 0);
    go(0, RET, 0, 2, 1, 0, 0, 0);
    go(0, 0, 0, 3, 0, 0, 0, 0);
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_ctrl_ras.md
Name: prog_ctrl_ras

Overview:
Parametrised next-generation program counter for the single-cycle core. It keeps the increment/absolute-branch behaviour and adds:
- selectable branch conditions
- PC-relative branches
- pipeline stall
- a hardware return-address stack (RAS) for call/return

It drives the instruction ROM address and sits between the decoder and instruction memory.

Parameters:
PC_W, 7, width of PC, target and stack entries
RAS_DEPTH, 4, number of return-address stack entries (>=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  core clock, rising-edge
reset  input  1  asynchronous active-low reset (0 = asserted)
stall  input  1  hold PC and stack this cycle
branch  input  1  branch request
branch_conditional  input  1  branch taken only if selected condition true
branch_rel  input  1  target is signed offset from current PC
cond_sel  input  2  0 zero, 1 not-zero, 2 negative, 3 not-negative
zero  input  1  ALU zero flag
neg  input  1  ALU sign flag
call  input  1  push PC+1, jump to target (absolute)
ret  input  1  pop stack into PC
target  input  PC_W  absolute address, or two's-complement offset when branch_rel
PC  output  PC_W  current instruction address
taken  output  1  registered: previous update was a non-sequential redirect
ras_count  output  $clog2(RAS_DEPTH+1)  current stack occupancy
ras_overflow  output  1  sticky: push attempted while full
ras_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset=0, asynchronous) forces the following; stack contents are don't-care:
  - PC=RESET_PC
  - taken=0
  - ras_count=0
  - ras_overflow=0
  - ras_underflow=0
- Release is synchronous to clk. The first update occurs on the first rising edge with reset=1.
- Every control decision updates state on the rising edge and is visible the next cycle. Latency is 1 cycle, as before.
- stall=1 takes precedence over everything below:
  - PC, stack, ras_count and sticky flags hold.
  - taken<=0.
- Otherwise the priority order is ret > call > branch > sequential.
- ret:
  - Non-empty stack: PC<=top entry, ras_count decrements, taken<=1.
  - Empty stack: ras_underflow<=1, PC<=PC+1, taken<=0.
- call:
  - Not full: push PC+1 (mod 2^PC_W), PC<=target, ras_count increments, taken<=1.
  - Full: push discarded, stack unchanged, ras_overflow<=1, jump still performed, taken<=1.
  - branch_rel is ignored for call.
- branch:
  - Condition cond = {zero, !zero, neg, !neg}[cond_sel].
  - Taken if branch && (!branch_conditional || cond).
  - Taken, branch_rel=0: PC<=target.
  - Taken, branch_rel=1: PC<=PC+sign-extended target (mod 2^PC_W).
  - taken<=1 whenever the branch is taken.
  - Not taken: PC<=PC+1, taken<=0.
- Sequential: PC<=PC+1. Wraps from 2^PC_W-1 to 0 with no flag.
- Simultaneous call and ret: ret wins, call ignored. Simultaneous call/ret with branch: branch ignored.
- Stack is LIFO and indexed by ras_count; no wrap-around overwrite.
- Sticky flags clear only on reset.
- A reset asserted mid-operation (including during stall) aborts immediately and loses the stack.

Optional Feature:
Macro PROG_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output perf_taken_cnt [15:0].
  - Counts cycles in which taken is set to 1 (non-stalled redirects).
  - Saturates at 16'hFFFF.
  - Reset to 0 asynchronously.
  - Holds during stall.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 130 free-running cycles, PC_W=7 -> PC runs 0..127, wraps to 0 at cycle 128, taken stays 0.
- PC=10, branch=1, branch_conditional=1, cond_sel=1, zero=1 -> PC=11, taken=0; next with zero=0, target=40 -> PC=40, taken=1.
- PC=20, branch=1, branch_rel=1, target=7'h7C (-4) -> PC=16; PC=126, offset +5 -> PC=3 (wrap).
- call target=50 at PC=5 -> PC=50, ras_count=1; ret -> PC=6, ras_count=0; extra ret -> ras_underflow=1, PC=7.
- Five nested calls with RAS_DEPTH=4 -> ras_overflow=1, ras_count=4, PC=5th target; four rets return to addresses 4..1 in LIFO order.
- stall=1 with call asserted for 3 cycles -> PC, ras_count unchanged, taken=0; async reset pulse mid-stall -> PC=RESET_PC, flags 0, without waiting for clk.
